// File: rtl/four_pr_chk.sv
// four_pr_chk: receive-side checker for the 4-bit QAM16 PRBS symbol stream
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   data_in[3:0], data_valid         demapped symbol and its one-cycle strobe
//   clear                            synchronous clear of the three counters
//   locked, err_pulse                lock status and per-error pulse
//   sym_cnt, err_cnt, bit_err_cnt    saturating counters, active only while locked
//   expected[3:0]                    predicted value of the next symbol
// Optional: define FOUR_PR_CHK_BITERR_EN to count bit errors; otherwise bit_err_cnt is 0.
module four_pr_chk #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       data_in,
   input  logic             data_valid,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] sym_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_err_cnt,
   output logic [3:0]       expected
);
   typedef enum logic {SEARCH, LOCKED} state_t;
   localparam logic [CNT_W-1:0] MAX = '1;
   state_t state, state_n;
   logic [3:0] pred, pred_n, match_cnt, match_n, consec_err, consec_n;
   logic seeded, seeded_n, pulse_n;
   logic [CNT_W-1:0] sym_n, err_n;
   function automatic logic [3:0] nxt(input logic [3:0] x);
      return {x[0], x[3] ^ x[0], x[2], x[1]};
   endfunction
   assign locked   = (state == LOCKED);
   assign expected = pred;
   always_comb begin
      state_n  = state;
      pred_n   = pred;
      match_n  = match_cnt;
      consec_n = consec_err;
      seeded_n = seeded;
      pulse_n  = 1'b0;
      sym_n    = sym_cnt;
      err_n    = err_cnt;
      if (data_valid && state == SEARCH) begin
         if (data_in == 4'd0)
            match_n = 4'd0;
         else if (seeded && data_in == pred) begin
            pred_n   = nxt(data_in);
            match_n  = (match_cnt == 4'(LOCK_CNT - 1)) ? 4'd0 : match_cnt + 4'd1;
            consec_n = 4'd0;
            state_n  = (match_cnt == 4'(LOCK_CNT - 1)) ? LOCKED : SEARCH;
         end else begin
            match_n  = 4'd0;
            pred_n   = nxt(data_in);
            seeded_n = 1'b1;
         end
      end else if (data_valid) begin
         pred_n   = nxt(pred);
         sym_n    = sym_cnt + CNT_W'(sym_cnt != MAX);
         consec_n = 4'd0;
         if (data_in != pred) begin
            pulse_n  = 1'b1;
            err_n    = err_cnt + CNT_W'(err_cnt != MAX);
            consec_n = consec_err + 4'd1;
            if (consec_err == 4'(LOSS_CNT - 1)) begin
               state_n  = SEARCH;
               match_n  = 4'd0;
               consec_n = 4'd0;
               pred_n   = (data_in == 4'd0) ? pred : nxt(data_in);
            end
         end
      end
      if (clear) begin
         sym_n = '0;
         err_n = '0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= SEARCH;
         pred       <= 4'b0001;
         match_cnt  <= 4'd0;
         consec_err <= 4'd0;
         seeded     <= 1'b0;
         err_pulse  <= 1'b0;
         sym_cnt    <= '0;
         err_cnt    <= '0;
      end else begin
         state      <= state_n;
         pred       <= pred_n;
         match_cnt  <= match_n;
         consec_err <= consec_n;
         seeded     <= seeded_n;
         err_pulse  <= pulse_n;
         sym_cnt    <= sym_n;
         err_cnt    <= err_n;
      end
   end
`ifdef FOUR_PR_CHK_BITERR_EN
   logic [3:0] diff;
   logic [CNT_W-1:0] pc, bit_n;
   always_comb begin
      diff  = data_in ^ pred;
      pc    = CNT_W'(diff[0]) + CNT_W'(diff[1]) + CNT_W'(diff[2]) + CNT_W'(diff[3]);
      bit_n = clear ? '0 :
              (state == LOCKED && data_valid && diff != 4'd0) ?
                 ((bit_err_cnt > MAX - pc) ? MAX : bit_err_cnt + pc) : bit_err_cnt;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         bit_err_cnt <= '0;
      else
         bit_err_cnt <= bit_n;
   end
`else
   assign bit_err_cnt = '0;
`endif
endmodule

// File: tb/tb_four_pr_chk.sv
// tb_four_pr_chk: directed bench for four_pr_chk with a behavioural reference model
module tb_four_pr_chk;
   localparam int LOCK_CNT = 4;
   localparam int LOSS_CNT = 3;
`ifdef FOUR_PR_CHK_BITERR_EN
   localparam int BE = 1;
`else
   localparam int BE = 0;
`endif
   logic clk = 1'b0, reset = 1'b0, data_valid = 1'b0, clear = 1'b0;
   logic [3:0] data_in = 4'd0;
   logic locked_a, err_pulse_a, locked_b, err_pulse_b;
   logic [15:0] sym_a, err_a, bit_a;
   logic [3:0] sym_b, err_b, bit_b, exp_a, exp_b;
   int n_chk = 0, n_err = 0;
   logic [3:0] g;
   always #5 clk = ~clk;
   four_pr_chk u_a (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear(clear),
      .locked(locked_a), .err_pulse(err_pulse_a), .sym_cnt(sym_a), .err_cnt(err_a),
      .bit_err_cnt(bit_a), .expected(exp_a));
   four_pr_chk #(.CNT_W(4)) u_b (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear(clear),
      .locked(locked_b), .err_pulse(err_pulse_b), .sym_cnt(sym_b), .err_cnt(err_b),
      .bit_err_cnt(bit_b), .expected(exp_b));
   function automatic logic [3:0] nxt(input logic [3:0] x);
      return {x[0], x[3] ^ x[0], x[2], x[1]};
   endfunction
   function automatic int lim(input int k);
      return k == 0 ? 65535 : 15;
   endfunction
   function automatic int sat(input int v, input int k);
      return v > lim(k) ? lim(k) : v;
   endfunction
   function automatic logic [3:0] corrupt(input logic [3:0] x);
      return (x ^ 4'hF) != 4'd0 ? x ^ 4'hF : 4'h3;
   endfunction
   // Reference model: in SEARCH it tracks the length of the current chain of
   // symbols that each follow their predecessor; a chain of LOCK_CNT+1 locks.
   logic m_locked, m_seeded, m_pulse;
   logic [3:0] m_prev, m_pred;
   int m_run, m_bad;
   int m_sym [2];
   int m_err [2];
   int m_bit [2];
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_locked <= 1'b0; m_seeded <= 1'b0; m_pulse <= 1'b0;
         m_prev <= 4'd0; m_pred <= 4'd0; m_run <= 0; m_bad <= 0;
         for (int k = 0; k < 2; k++) begin m_sym[k] <= 0; m_err[k] <= 0; m_bit[k] <= 0; end
      end else begin
         m_pulse <= 1'b0;
         if (data_valid && !m_locked) begin
            if (data_in == 4'd0) m_run <= m_seeded ? 1 : 0;
            else if (m_seeded && data_in == nxt(m_prev)) begin
               m_run <= m_run + 1;
               m_prev <= data_in;
               if (m_run == LOCK_CNT) begin m_locked <= 1'b1; m_pred <= nxt(data_in); m_bad <= 0; end
            end else begin m_run <= 1; m_prev <= data_in; m_seeded <= 1'b1; end
         end else if (data_valid) begin
            m_pred <= nxt(m_pred);
            for (int k = 0; k < 2; k++) m_sym[k] <= sat(m_sym[k] + 1, k);
            if (data_in == m_pred) m_bad <= 0;
            else begin
               m_pulse <= 1'b1;
               for (int k = 0; k < 2; k++) begin
                  m_err[k] <= sat(m_err[k] + 1, k);
                  m_bit[k] <= sat(m_bit[k] + BE * $countones(data_in ^ m_pred), k);
               end
               if (m_bad + 1 == LOSS_CNT) begin
                  m_locked <= 1'b0; m_bad <= 0; m_run <= 1; m_prev <= data_in; m_seeded <= 1'b1;
               end else m_bad <= m_bad + 1;
            end
         end
         if (clear) for (int k = 0; k < 2; k++) begin m_sym[k] <= 0; m_err[k] <= 0; m_bit[k] <= 0; end
      end
   end
   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
      end
   endtask
   task automatic cmp();
      logic [3:0] e;
      e = m_locked ? m_pred : (m_seeded ? nxt(m_prev) : 4'd1);
      chk("locked_a", int'(locked_a), int'(m_locked));
      chk("locked_b", int'(locked_b), int'(m_locked));
      chk("pulse_a", int'(err_pulse_a), int'(m_pulse));
      chk("pulse_b", int'(err_pulse_b), int'(m_pulse));
      chk("expected_a", int'(exp_a), int'(e));
      chk("expected_b", int'(exp_b), int'(e));
      chk("sym_a", int'(sym_a), m_sym[0]);
      chk("sym_b", int'(sym_b), m_sym[1]);
      chk("err_a", int'(err_a), m_err[0]);
      chk("err_b", int'(err_b), m_err[1]);
      chk("bit_a", int'(bit_a), m_bit[0]);
      chk("bit_b", int'(bit_b), m_bit[1]);
   endtask
   task automatic tick(input logic v, input logic [3:0] d, input logic c);
      @(negedge clk);
      cmp();
      data_valid = v; data_in = d; clear = c;
   endtask
   task automatic sym(input logic [3:0] d);
      tick(1'b1, d, 1'b0);
      repeat (10) tick(1'b0, 4'd0, 1'b0);
   endtask
   task automatic good();
      sym(g); g = nxt(g);
   endtask
   task automatic bad();
      sym(corrupt(g)); g = nxt(g);
   endtask
   task automatic do_reset();
      reset = 1'b0;
      repeat (2) tick(1'b0, 4'd0, 1'b0);
      @(negedge clk) reset = 1'b1;
   endtask
   initial begin
      g = 4'd1;
      repeat (2) tick(1'b0, 4'd0, 1'b0);
      chk("rst_locked", int'(locked_a), 0);
      chk("rst_expected", int'(exp_a), 1);
      chk("rst_sym", int'(sym_a), 0);
      @(negedge clk) reset = 1'b1;
      repeat (4) good();
      chk("pre_lock", int'(locked_a), 0);
      good();
      chk("lock_5th", int'(locked_a), 1);
      chk("lock_expected", int'(exp_a), 10);
      repeat (25) good();
      chk("clean_sym", int'(sym_a), 25);
      chk("clean_err", int'(err_a), 0);
      chk("sat_sym", int'(sym_b), 15);
      while (g != 4'b0101) good();
      sym(4'b0100); g = nxt(g);
      chk("single_err", int'(err_a), 1);
      chk("single_bit", int'(bit_a), BE);
      chk("single_locked", int'(locked_a), 1);
      while (g != 4'b0001) good();
      good(); bad(); bad(); good();
      chk("consec_cleared", int'(locked_a), 1);
      chk("consec_err", int'(err_a), 3);
      tick(1'b0, 4'd0, 1'b1);
      tick(1'b0, 4'd0, 1'b0);
      chk("clear_err", int'(err_a), 0);
      repeat (3) bad();
      chk("loss_err", int'(err_a), 3);
      chk("loss_bit", int'(bit_a), 12 * BE);
      chk("loss_locked", int'(locked_a), 0);
      repeat (4) good();
      chk("relock_pre", int'(locked_a), 0);
      good();
      chk("relock", int'(locked_a), 1);
      do_reset();
      repeat (50) tick(1'b1, 4'd0, 1'b0);
      tick(1'b0, 4'd0, 1'b0);
      chk("zero_locked", int'(locked_a), 0);
      chk("zero_expected", int'(exp_a), 1);
      chk("zero_sym", int'(sym_a), 0);
      g = 4'd1;
      repeat (5) good();
      chk("sat_lock", int'(locked_b), 1);
      repeat (20) begin bad(); good(); end
      chk("sat_err_b", int'(err_b), 15);
      chk("sat_err_a", int'(err_a), 20);
      tick(1'b1, corrupt(g), 1'b1); g = nxt(g);
      tick(1'b0, 4'd0, 1'b0);
      chk("clear_prio_b", int'(err_b), 0);
      chk("clear_prio_a", int'(err_a), 0);
      chk("clear_pulse", int'(err_pulse_a), 1);
      repeat (3) tick(1'b0, 4'd0, 1'b0);
      good();
      chk("async_pre", int'(locked_a), 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_locked", int'(locked_a), 0);
      chk("async_sym", int'(sym_a), 0);
      chk("async_expected", int'(exp_a), 1);
      chk("async_err_b", int'(err_b), 0);
      repeat (2) tick(1'b0, 4'd0, 1'b0);
      @(negedge clk) reset = 1'b1;
      repeat (2) tick(1'b0, 4'd0, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
